// File: rtl/hex_counter_4dig.sv
// hex_counter_4dig: four-digit hex/BCD event counter with prescaler and start/stop/clear control
// Ports: clk; rst_n (async, active-low); start/stop/clear single-cycle pulses; up_dn (1 = up);
//   d0..d3 registered digit nibbles (d0 least significant); running high while in RUN;
//   wrap one-cycle pulse on full-count rollover in either direction.
// Macro HEX_COUNTER_BCD_MODE_EN: digits count 0-9 instead of 0-F.
module hex_counter_4dig #(
  parameter int PRESCALE = 50000000,
  parameter int PS_W = 26
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  input  logic       up_dn,
  output logic [3:0] d0,
  output logic [3:0] d1,
  output logic [3:0] d2,
  output logic [3:0] d3,
  output logic       running,
  output logic       wrap
);
`ifdef HEX_COUNTER_BCD_MODE_EN
  localparam logic [3:0] DMAX = 4'd9;
`else
  localparam logic [3:0] DMAX = 4'hf;
`endif
  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
  state_t state_q, state_d;
  logic [PS_W-1:0] ps_q, ps_d;
  logic [3:0][3:0] dig_q, dig_d, dig_nx;
  logic running_q, running_d, wrap_q, wrap_d, step, cy, lim;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  // stop outranks start even where stop itself has no effect
  always_comb
    state_d = clear ? IDLE :
              (stop && state_q == RUN) ? PAUSE :
              (start && !stop && state_q != RUN) ? RUN : state_q;
  always_comb running_d = state_d == RUN;
  assign step = state_q == RUN && ps_q == PS_W'(PRESCALE - 1);
  // ripple carry/borrow across digits; cy left set means the whole count rolled over
  always_comb begin
    cy = 1'b1;
    lim = 1'b0;
    dig_nx = dig_q;
    for (int i = 0; i < 4; i++) begin
      lim = up_dn ? dig_q[i] == DMAX : dig_q[i] == 4'd0;
      dig_nx[i] = !cy ? dig_q[i] : lim ? (up_dn ? 4'd0 : DMAX) :
                  up_dn ? dig_q[i] + 4'd1 : dig_q[i] - 4'd1;
      cy = cy && lim;
    end
  end
  // prescaler holds in PAUSE so a resume keeps the partial period
  always_comb begin
    ps_d = (clear || state_q == IDLE) ? '0 : state_q != RUN ? ps_q : step ? '0 : ps_q + 1'b1;
    dig_d = clear ? '0 : step ? dig_nx : dig_q;
    wrap_d = !clear && step && cy;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ps_q <= '0;
      dig_q <= '0;
      running_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      ps_q <= ps_d;
      dig_q <= dig_d;
      running_q <= running_d;
      wrap_q <= wrap_d;
    end
  assign {d3, d2, d1, d0} = dig_q;
  assign running = running_q;
  assign wrap = wrap_q;
endmodule

// File: tb/tb_hex_counter_4dig.sv
// tb_hex_counter_4dig: scoreboard bench for hex_counter_4dig with PRESCALE=4
module tb_hex_counter_4dig;
  localparam int P = 4;
`ifdef HEX_COUNTER_BCD_MODE_EN
  localparam int MOD = 10000;
  localparam logic [15:0] ALLMAX = 16'h9999;
  localparam logic [15:0] AT256 = 16'h0256;
`else
  localparam int MOD = 65536;
  localparam logic [15:0] ALLMAX = 16'hffff;
  localparam logic [15:0] AT256 = 16'h0100;
`endif
  typedef struct packed {
    logic [15:0] dig;
    logic run;
    logic wrap;
  } exp_t;
  logic clk = 0, rst_n = 0, start = 0, stop = 0, clear = 0, up_dn = 1;
  logic [3:0] d0, d1, d2, d3;
  logic running, wrap;
  exp_t exp_q[$];
  exp_t e;
  int n_cmp = 0, n_bad = 0;
  int m_st = 0, m_ps = 0, m_cnt = 0;
  logic m_wrap = 0;
  hex_counter_4dig #(.PRESCALE(P), .PS_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .clear(clear), .up_dn(up_dn),
    .d0(d0), .d1(d1), .d2(d2), .d3(d3), .running(running), .wrap(wrap)
  );
  always #5 clk = ~clk;
  function automatic logic [15:0] enc(input int v);
`ifdef HEX_COUNTER_BCD_MODE_EN
    return {4'(v / 1000), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
`else
    return 16'(v);
`endif
  endfunction
  task automatic tick(input logic st, input logic sp, input logic cl, input logic ud);
    logic stp;
    exp_t x;
    start = st;
    stop = sp;
    clear = cl;
    up_dn = ud;
    stp = m_st == 1 && m_ps == P - 1;
    m_wrap = !cl && stp && (ud ? m_cnt == MOD - 1 : m_cnt == 0);
    if (cl) m_cnt = 0;
    else if (stp) m_cnt = ud ? (m_cnt + 1) % MOD : (m_cnt + MOD - 1) % MOD;
    m_ps = (cl || m_st == 0) ? 0 : m_st == 2 ? m_ps : stp ? 0 : m_ps + 1;
    if (cl) m_st = 0;
    else if (sp && m_st == 1) m_st = 2;
    else if (st && !sp && m_st != 1) m_st = 1;
    x.dig = enc(m_cnt);
    x.run = m_st == 1;
    x.wrap = m_wrap;
    exp_q.push_back(x);
    @(posedge clk);
    #1;
    start = 0;
    stop = 0;
    clear = 0;
  endtask
  task automatic test_reset;
    #8;
    n_cmp++;
    if ({d3, d2, d1, d0} !== 16'h0 || running !== 1'b0 || wrap !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_state: got dig=%h run=%b wrap=%b need 0000/0/0", {d3, d2, d1, d0}, running, wrap);
    end
    #4 rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      tick(0, 0, 0, 1);
      e = exp_q.pop_front();
      n_cmp++;
      if ({d3, d2, d1, d0} !== e.dig || running !== e.run || wrap !== e.wrap) begin
        n_bad++;
        $display("FAIL reset_idle c%0d: got %h/%b/%b need %h/%b/%b", i, {d3, d2, d1, d0}, running, wrap, e.dig, e.run, e.wrap);
      end
    end
  endtask
  task automatic test_up_count;
    for (int i = 0; i < 17; i++) begin
      tick(i == 0, 0, 0, 1);
      e = exp_q.pop_front();
      n_cmp++;
      if ({d3, d2, d1, d0} !== e.dig || running !== e.run || wrap !== e.wrap) begin
        n_bad++;
        $display("FAIL up_count c%0d: got %h/%b/%b need %h/%b/%b", i, {d3, d2, d1, d0}, running, wrap, e.dig, e.run, e.wrap);
      end
    end
    n_cmp++;
    if ({d3, d2, d1, d0} !== 16'h0004 || running !== 1'b1) begin
      n_bad++;
      $display("FAIL up_count_end: got dig=%h run=%b need 0004/1", {d3, d2, d1, d0}, running);
    end
  endtask
  task automatic test_carry;
    for (int i = 0; i < 252 * P; i++) begin
      tick(0, 0, 0, 1);
      e = exp_q.pop_front();
      n_cmp++;
      if ({d3, d2, d1, d0} !== e.dig || running !== e.run || wrap !== e.wrap) begin
        n_bad++;
        $display("FAIL carry c%0d: got %h/%b/%b need %h/%b/%b", i, {d3, d2, d1, d0}, running, wrap, e.dig, e.run, e.wrap);
      end
    end
    n_cmp++;
    if ({d3, d2, d1, d0} !== AT256 || wrap !== 1'b0) begin
      n_bad++;
      $display("FAIL carry_256: got dig=%h wrap=%b need %h/0", {d3, d2, d1, d0}, wrap, AT256);
    end
  endtask
  task automatic test_down_wrap;
    for (int i = 0; i < 6; i++) begin
      tick(i == 1, 0, i == 0, 0);
      e = exp_q.pop_front();
      n_cmp++;
      if ({d3, d2, d1, d0} !== e.dig || running !== e.run || wrap !== e.wrap) begin
        n_bad++;
        $display("FAIL down_wrap c%0d: got %h/%b/%b need %h/%b/%b", i, {d3, d2, d1, d0}, running, wrap, e.dig, e.run, e.wrap);
      end
    end
    n_cmp++;
    if ({d3, d2, d1, d0} !== ALLMAX || wrap !== 1'b1) begin
      n_bad++;
      $display("FAIL down_wrap_end: got dig=%h wrap=%b need %h/1", {d3, d2, d1, d0}, wrap, ALLMAX);
    end
    for (int i = 0; i < 4; i++) begin
      tick(0, 0, 0, i == 3 ? 1'b1 : 1'(i % 2));
      e = exp_q.pop_front();
      n_cmp++;
      if ({d3, d2, d1, d0} !== e.dig || running !== e.run || wrap !== e.wrap) begin
        n_bad++;
        $display("FAIL up_wrap c%0d: got %h/%b/%b need %h/%b/%b", i, {d3, d2, d1, d0}, running, wrap, e.dig, e.run, e.wrap);
      end
    end
    n_cmp++;
    if ({d3, d2, d1, d0} !== 16'h0 || wrap !== 1'b1) begin
      n_bad++;
      $display("FAIL up_wrap_end: got dig=%h wrap=%b need 0000/1", {d3, d2, d1, d0}, wrap);
    end
    tick(0, 0, 0, 1);
    void'(exp_q.pop_front());
    n_cmp++;
    if (wrap !== 1'b0) begin
      n_bad++;
      $display("FAIL wrap_one_cycle: got wrap=%b need 0", wrap);
    end
  endtask
  task automatic test_pause_resume;
    for (int i = 0; i < 18; i++) begin
      tick(i == 1 || i == 15, i == 3, i == 0, 1);
      e = exp_q.pop_front();
      n_cmp++;
      if ({d3, d2, d1, d0} !== e.dig || running !== e.run || wrap !== e.wrap) begin
        n_bad++;
        $display("FAIL pause c%0d: got %h/%b/%b need %h/%b/%b", i, {d3, d2, d1, d0}, running, wrap, e.dig, e.run, e.wrap);
      end
      if (i == 16) begin
        n_cmp++;
        if ({d3, d2, d1, d0} !== 16'h0) begin
          n_bad++;
          $display("FAIL resume_early: got dig=%h need 0000", {d3, d2, d1, d0});
        end
      end
    end
    n_cmp++;
    if ({d3, d2, d1, d0} !== 16'h0001 || running !== 1'b1) begin
      n_bad++;
      $display("FAIL resume_step: got dig=%h run=%b need 0001/1", {d3, d2, d1, d0}, running);
    end
  endtask
  task automatic test_priority;
    for (int i = 0; i < 15; i++) begin
      tick(i == 1 || i == 13, i == 13, i == 0 || i == 13, 1);
      e = exp_q.pop_front();
      n_cmp++;
      if ({d3, d2, d1, d0} !== e.dig || running !== e.run || wrap !== e.wrap) begin
        n_bad++;
        $display("FAIL priority c%0d: got %h/%b/%b need %h/%b/%b", i, {d3, d2, d1, d0}, running, wrap, e.dig, e.run, e.wrap);
      end
      if (i == 13) begin
        n_cmp++;
        if ({d3, d2, d1, d0} !== 16'h0 || running !== 1'b0 || wrap !== 1'b0) begin
          n_bad++;
          $display("FAIL priority_clear: got %h/%b/%b need 0000/0/0", {d3, d2, d1, d0}, running, wrap);
        end
      end
    end
  endtask
  task automatic test_async_reset;
    for (int i = 0; i < 7; i++) begin
      tick(i == 0, 0, 0, 1);
      void'(exp_q.pop_front());
    end
    #2 rst_n = 0;
    #1;
    n_cmp++;
    if ({d3, d2, d1, d0} !== 16'h0 || running !== 1'b0 || wrap !== 1'b0) begin
      n_bad++;
      $display("FAIL async_reset: got %h/%b/%b need 0000/0/0", {d3, d2, d1, d0}, running, wrap);
    end
    m_st = 0;
    m_ps = 0;
    m_cnt = 0;
    #3 rst_n = 1;
    for (int i = 0; i < 6; i++) begin
      tick(0, 0, 0, 1);
      e = exp_q.pop_front();
      n_cmp++;
      if ({d3, d2, d1, d0} !== e.dig || running !== e.run || wrap !== e.wrap) begin
        n_bad++;
        $display("FAIL post_reset c%0d: got %h/%b/%b need %h/%b/%b", i, {d3, d2, d1, d0}, running, wrap, e.dig, e.run, e.wrap);
      end
    end
  endtask
  initial begin
    test_reset;
    test_up_count;
    test_carry;
    test_down_wrap;
    test_pause_resume;
    test_priority;
    test_async_reset;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/hex_counter_4dig.md
Name: hex_counter_4dig

Overview:
Four-digit hex/BCD event counter that generates the nibbles driving the board's seven-segment decoders, one decoder per digit. A prescaler turns the system clock into a count step. A start/stop/clear control FSM and an up/down select govern counting. Each digit output connects directly to the 4-bit hex input of a downstream segment decoder.

Parameters:
PRESCALE, 50000000, clock cycles per count step (1 Hz at 50 MHz); legal range is 2 or more.
PS_W, 26, prescaler counter width; must satisfy 2^PS_W >= PRESCALE.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst_n  input  1  reset, asynchronous, active-low.
start  input  1  single-cycle pulse (debounced upstream); begin or resume counting.
stop  input  1  single-cycle pulse; pause counting.
clear  input  1  single-cycle pulse; zero the count and return to IDLE.
up_dn  input  1  1 = count up, 0 = count down; sampled only on step cycles.
d0  output  4  least-significant digit, registered.
d1  output  4  digit 1, registered.
d2  output  4  digit 2, registered.
d3  output  4  most-significant digit, registered.
running  output  1  high while in RUN.
wrap  output  1  one-cycle pulse when the full count rolls over in either direction.

Behaviour:
- Reset (rst_n low, asynchronous): state = IDLE; d0 through d3 = 0; prescaler = 0; running = 0; wrap = 0.
- FSM states and transitions:
  - IDLE: start goes to RUN.
  - RUN: stop goes to PAUSE.
  - PAUSE: start goes to RUN.
  - clear from any state goes to IDLE.
  - start in RUN is ignored. stop in IDLE or PAUSE is ignored.
- Priority when inputs coincide in one cycle: clear > stop > start.
- clear effect: the next edge sets the digits to 0, the prescaler to 0 and wrap to 0, even in RUN on a step cycle.
- running is registered and equals (state == RUN). It rises on the edge that enters RUN.
- Prescaler:
  - Increments only in RUN.
  - When it is at PRESCALE-1 in RUN, that cycle is a step cycle and the prescaler returns to 0.
  - In PAUSE it holds its value, so a resume keeps the partial period.
  - It is zeroed on entry to IDLE.
- First step timing: after start from IDLE, the first step cycle is the PRESCALE-th RUN cycle. The digits change on the following edge.
- Step, up (up_dn = 1):
  - d0 increments.
  - Any digit at its maximum (F) wraps to 0 and carries into the next digit in the same edge.
  - A carry out of d3 (FFFF to 0000) asserts wrap for exactly one cycle, coincident with the digit update.
- Step, down (up_dn = 0):
  - d0 decrements.
  - Any digit at 0 wraps to its maximum and borrows from the next digit.
  - 0000 to FFFF asserts wrap for one cycle.
- up_dn changes outside step cycles have no effect. A direction change takes effect on the next step with no glitch.
- Latency: digits and wrap update on the clock edge that ends the step cycle. Outputs never change on a non-step cycle except through clear or reset.
- Reset asserted mid-operation overrides everything. After release the block is in IDLE and requires start.

Optional Feature:
Macro: HEX_COUNTER_BCD_MODE_EN.
- Defined: each digit counts 0 to 9 (decimal).
  - Up: 9 wraps to 0 with carry; 9999 to 0000 pulses wrap.
  - Down: 0 wraps to 9 with borrow; 0000 to 9999 pulses wrap.
  - Digit values A through F never appear on d0 to d3.
- Undefined: hex operation as above; digit maximum is F.

Test Plan:
1. Up count: PRESCALE=4, reset, start pulse, up_dn=1, run 16 RUN cycles -> digits=0004; running=1; d0 updates every 4th cycle.
2. Carry chain: count up from 00FF (hex build) -> next step gives 0100. Count up from FFFF -> next step gives 0000 with wrap=1 for exactly one cycle.
3. Down wrap: from 0000 with up_dn=0, one step -> FFFF (hex) or 9999 (HEX_COUNTER_BCD_MODE_EN defined); wrap pulse on the same edge.
4. Pause/resume: stop 2 cycles into a 4-cycle period, hold 10 cycles -> digits and prescaler frozen. Start -> next step occurs 2 RUN cycles later.
5. Priority: clear, stop and start all asserted in one RUN step cycle -> next edge gives digits 0000, state IDLE, running=0, wrap=0.
6. Async reset: drop rst_n mid-period between edges -> outputs go to 0 immediately without a clock. After release, no counting until start.
